// File: rtl/keypad_pkg.sv
// keypad_pkg: width helpers and event-word layout shared by the keypad scanner and its event FIFO.
// Latency: none (compile-time functions only).
// Backpressure: not applicable.
package keypad_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic int key_width(input int rows, input int cols);
        return (clog2(rows * cols) > 0) ? clog2(rows * cols) : 1;
    endfunction

    // Event word: key code in the low bits, release flag in the MSB.
    function automatic int evt_width(input int kw);
        return kw + 1;
    endfunction

    function automatic int evt_rel_bit(input int kw);
        return kw;
    endfunction

endpackage

// File: rtl/keypad_evt_fifo.sv
// keypad_evt_fifo: small synchronous FIFO holding key events; head reads as zero while empty.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push into a full FIFO is ignored unless a pop happens in the same cycle.
module keypad_evt_fifo import keypad_pkg::*; #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] dat_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);
    localparam int AW = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    always_comb begin
        empty_o = (cnt_q == '0);
        full_o  = (cnt_q == (AW+1)'(DEPTH));
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        rd_d    = rd_q + AW'(do_pop);
        wr_d    = wr_q + AW'(do_push);
        cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        head_o  = empty_o ? '0 : mem_q[rd_q];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= dat_i;
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: column-strobed matrix scan with per-key debounce and a press/release event FIFO; KEYPAD_REPEAT_EN adds auto-repeat.
// Latency: a key changes state on its DEBOUNCE_SCANS-th differing frame sample, pushed in its processing slot; o_evt_valid one cycle later.
// Backpressure: events wait in the FIFO while i_evt_ready is low; a push into a full FIFO is dropped and sets sticky o_overflow.
module keypad_scanner import keypad_pkg::*; #(
    parameter int ROWS           = 5,
    parameter int COLS           = 4,
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 3,
    parameter int FIFO_DEPTH     = 4,
    parameter int REPEAT_FRAMES  = 50,
    localparam int KW            = key_width(ROWS, COLS)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic [COLS-1:0] o_key_out,
    input  logic [ROWS-1:0] i_key_in,
    output logic            o_evt_valid,
    input  logic            i_evt_ready,
    output logic [KW-1:0]   o_evt_code,
    output logic            o_evt_release,
    output logic            o_overflow
);
    localparam int NK   = ROWS * COLS;
    localparam int CW   = clog2(SCAN_DIV);
    localparam int COLW = clog2(COLS);
    localparam int RW   = (clog2(ROWS) > 0) ? clog2(ROWS) : 1;
    localparam int DW   = clog2(DEBOUNCE_SCANS + 1);
    localparam int EW   = evt_width(KW);

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [COLW-1:0] col_q, col_d, pcol_q, pcol_d;
    logic [ROWS-1:0] rows_q, rows_d;
    logic [NK-1:0]   stable_q, stable_d;
    logic [DW-1:0]   dcnt_q [NK];
    logic [DW-1:0]   dcnt_d [NK];
    logic            ovf_q, ovf_d;

    logic            dwell_end, win, samp, push, push_rel, pop, fifo_full, fifo_empty;
    logic [KW-1:0]   key_idx;
    logic [RW-1:0]   row_idx;
    logic [EW-1:0]   head;

`ifdef KEYPAD_REPEAT_EN
    localparam int RPW = clog2(REPEAT_FRAMES + 1);
    logic [KW-1:0]   rep_key_q, rep_key_d;
    logic            rep_on_q, rep_on_d;
    logic [RPW-1:0]  rep_cnt_q, rep_cnt_d;
`endif

    always_comb begin
        dwell_end = (cnt_q == CW'(SCAN_DIV - 1));
        cnt_d     = dwell_end ? '0 : cnt_q + CW'(1);
        col_d     = col_q;
        pcol_d    = pcol_q;
        rows_d    = rows_q;
        // The latched rows belong to the column just left; pcol remembers which one.
        if (dwell_end) begin
            col_d  = (col_q == COLW'(COLS - 1)) ? '0 : col_q + COLW'(1);
            pcol_d = col_q;
            rows_d = i_key_in;
        end

        win      = (cnt_q < CW'(ROWS));
        row_idx  = RW'(cnt_q);
        key_idx  = KW'(pcol_q) * KW'(ROWS) + KW'(cnt_q);
        samp     = rows_q[row_idx];
        stable_d = stable_q;
        dcnt_d   = dcnt_q;
        push     = 1'b0;
        push_rel = 1'b0;
        if (win) begin
            if (samp == stable_q[key_idx]) begin
                dcnt_d[key_idx] = '0;
            end else if (dcnt_q[key_idx] == DW'(DEBOUNCE_SCANS - 1)) begin
                stable_d[key_idx] = ~stable_q[key_idx];
                dcnt_d[key_idx]   = '0;
                push              = 1'b1;
                push_rel          = stable_q[key_idx];
            end else begin
                dcnt_d[key_idx] = dcnt_q[key_idx] + DW'(1);
            end
        end

`ifdef KEYPAD_REPEAT_EN
        rep_key_d = rep_key_q;
        rep_on_d  = rep_on_q;
        rep_cnt_d = rep_cnt_q;
        // The repeat frame count advances once per frame, in the tracked key's own slot.
        if (win) begin
            if (push && !push_rel) begin
                rep_key_d = key_idx;
                rep_on_d  = 1'b1;
                rep_cnt_d = '0;
            end else if (rep_on_q && key_idx == rep_key_q) begin
                if (push) begin
                    rep_on_d = 1'b0;
                end else if (samp != stable_q[key_idx]) begin
                    rep_cnt_d = '0;
                end else if (rep_cnt_q == RPW'(REPEAT_FRAMES - 1)) begin
                    rep_cnt_d = '0;
                    push      = 1'b1;
                    push_rel  = 1'b0;
                end else begin
                    rep_cnt_d = rep_cnt_q + RPW'(1);
                end
            end
        end
`endif

        o_evt_valid   = !fifo_empty;
        pop           = o_evt_valid && i_evt_ready;
        ovf_d         = ovf_q | (push & fifo_full & ~pop);
        o_overflow    = ovf_q;
        o_key_out     = COLS'(1) << col_q;
        o_evt_code    = head[KW-1:0];
        o_evt_release = head[evt_rel_bit(KW)];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q    <= '0;
            col_q    <= '0;
            pcol_q   <= '0;
            rows_q   <= '0;
            stable_q <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < NK; i++) dcnt_q[i] <= '0;
`ifdef KEYPAD_REPEAT_EN
            rep_key_q <= '0;
            rep_on_q  <= 1'b0;
            rep_cnt_q <= '0;
`endif
        end else begin
            cnt_q    <= cnt_d;
            col_q    <= col_d;
            pcol_q   <= pcol_d;
            rows_q   <= rows_d;
            stable_q <= stable_d;
            ovf_q    <= ovf_d;
            for (int i = 0; i < NK; i++) dcnt_q[i] <= dcnt_d[i];
`ifdef KEYPAD_REPEAT_EN
            rep_key_q <= rep_key_d;
            rep_on_q  <= rep_on_d;
            rep_cnt_q <= rep_cnt_d;
`endif
        end
    end

    keypad_evt_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .push_i  (push),
        .pop_i   (pop),
        .dat_i   ({push_rel, key_idx}),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head)
    );

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model driving rows from the column strobe, event collector, frame-level reference model.
module tb_keypad_scanner;
    localparam int ROWS  = 5;
    localparam int COLS  = 4;
    localparam int SDIV  = 8;
    localparam int DB    = 3;
    localparam int DEPTH = 4;
    localparam int RF    = 2;
    localparam int NK    = ROWS * COLS;
    localparam int FRAME = COLS * SDIV;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [COLS-1:0] key_out;
    logic [ROWS-1:0] key_in;
    logic            evt_valid;
    logic            evt_ready = 1'b0;
    logic [4:0]      evt_code;
    logic            evt_release;
    logic            overflow;
    logic [NK-1:0]   pressed = '0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int vcount = 0;
    int got[$];

    keypad_scanner #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SDIV), .DEBOUNCE_SCANS(DB),
        .FIFO_DEPTH(DEPTH), .REPEAT_FRAMES(RF)
    ) dut (
        .i_clk(clk), .i_rst(rst), .o_key_out(key_out), .i_key_in(key_in),
        .o_evt_valid(evt_valid), .i_evt_ready(evt_ready), .o_evt_code(evt_code),
        .o_evt_release(evt_release), .o_overflow(overflow)
    );

    always #5 clk = ~clk;

    // Keypad: a pressed key connects its row to its column while that column is driven.
    always_comb begin
        key_in = '0;
        for (int c = 0; c < COLS; c++)
            if (key_out[c]) key_in = key_in | pressed[c*ROWS +: ROWS];
    end

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Event encoding in the bench: release*32 + code.
    always @(negedge clk) begin
        if (evt_valid) vcount++;
        if (!rst && evt_valid && evt_ready) got.push_back(int'(evt_release) * 32 + int'(evt_code));
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic align();
        while (cyc % FRAME != 0) tick(1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pressed = '0;
        evt_ready = 1'b0;
        tick(3);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (key_out !== 4'b0001) begin errors++; $display("FAIL reset_key_out got %b want 0001", key_out); end
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", evt_valid); end
        checks++; if (evt_code !== 5'd0) begin errors++; $display("FAIL reset_code got %0d want 0", evt_code); end
        checks++; if (evt_release !== 1'b0) begin errors++; $display("FAIL reset_release got %b want 0", evt_release); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    endtask

    task automatic test_scan();
        logic [COLS-1:0] exp;
        for (int i = 0; i <= COLS; i++) begin
            exp = COLS'(1) << (i % COLS);
            checks++;
            if (key_out !== exp) begin errors++; $display("FAIL scan_col%0d got %b want %b", i, key_out, exp); end
            tick(SDIV);
        end
    endtask

    task automatic test_press_release();
        int base;
        align();
        evt_ready = 1'b1;
        base = got.size();
        pressed[7] = 1'b1;
        tick(2 * FRAME + 2 * SDIV + 2);
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL press_early valid got %b want 0", evt_valid); end
        tick(1);
        checks++;
        if (evt_valid !== 1'b1 || evt_code !== 5'd7 || evt_release !== 1'b0) begin
            errors++; $display("FAIL press_latency valid %b code %0d rel %b want 1 7 0", evt_valid, evt_code, evt_release);
        end
        tick(4 * FRAME - (2 * FRAME + 2 * SDIV + 3));
        pressed[7] = 1'b0;
        tick(5 * FRAME);
        checks++; if (got.size() - base != 2) begin errors++; $display("FAIL pr_count got %0d want 2", got.size() - base); end
        checks++; if (got.size() > base && got[base] != 7) begin errors++; $display("FAIL pr_press got %0d want 7", got[base]); end
        checks++; if (got.size() > base + 1 && got[base+1] != 39) begin errors++; $display("FAIL pr_release got %0d want 39", got[base+1]); end
    endtask

    task automatic test_glitch();
        int base, v0;
        align();
        evt_ready = 1'b1;
        base = got.size();
        v0 = vcount;
        pressed[0] = 1'b1;
        tick(2 * FRAME);
        pressed[0] = 1'b0;
        tick(4 * FRAME);
        checks++; if (got.size() != base) begin errors++; $display("FAIL glitch_events got %0d want 0", got.size() - base); end
        checks++; if (vcount != v0) begin errors++; $display("FAIL glitch_valid got %0d valid cycles want 0", vcount - v0); end
    endtask

    task automatic test_overflow();
        int base;
        do_reset();
        pressed[4:0] = 5'h1f;
        tick(4 * FRAME);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
        checks++; if (evt_valid !== 1'b1 || evt_code !== 5'd0) begin errors++; $display("FAIL ovf_head valid %b code %0d want 1 0", evt_valid, evt_code); end
        base = got.size();
        evt_ready = 1'b1;
        tick(6);
        evt_ready = 1'b0;
        checks++; if (got.size() - base != 4) begin errors++; $display("FAIL ovf_drain_count got %0d want 4", got.size() - base); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got.size() > base + i && got[base+i] != i) begin errors++; $display("FAIL ovf_drain%0d got %0d want %0d", i, got[base+i], i); end
        end
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty valid got %b want 0", evt_valid); end
        align();
        pressed = '0;
        evt_ready = 1'b1;
        tick(5 * FRAME);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    endtask

    task automatic test_simul_push_pop();
        int base;
        int exp[5] = '{0, 1, 2, 3, 5};
        do_reset();
        pressed[3:0] = 4'hf;
        pressed[5] = 1'b1;
        base = got.size();
        tick(2 * FRAME + 2 * SDIV);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL simul_overflow got %b want 0", overflow); end
        checks++; if (evt_code !== 5'd1) begin errors++; $display("FAIL simul_head got %0d want 1", evt_code); end
        evt_ready = 1'b1;
        tick(8);
        checks++; if (got.size() - base != 5) begin errors++; $display("FAIL simul_count got %0d want 5", got.size() - base); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got.size() > base + i && got[base+i] != exp[i]) begin errors++; $display("FAIL simul_order%0d got %0d want %0d", i, got[base+i], exp[i]); end
        end
        align();
        pressed = '0;
        tick(5 * FRAME);
    endtask

    task automatic test_reset_mid();
        int base;
        do_reset();
        pressed[7] = 1'b1;
        tick(4 * FRAME);
        checks++; if (evt_valid !== 1'b1 || evt_code !== 5'd7) begin errors++; $display("FAIL mid_pending valid %b code %0d want 1 7", evt_valid, evt_code); end
        tick(13);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        checks++; if (evt_valid !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL mid_cleared valid %b ovf %b want 0 0", evt_valid, overflow); end
        base = got.size();
        evt_ready = 1'b1;
        tick(2 * FRAME);
        checks++; if (got.size() != base) begin errors++; $display("FAIL mid_early got %0d events want 0", got.size() - base); end
        tick(2 * FRAME);
        checks++; if (got.size() - base != 1) begin errors++; $display("FAIL mid_count got %0d want 1", got.size() - base); end
        checks++; if (got.size() > base && got[base] != 7) begin errors++; $display("FAIL mid_redetect got %0d want 7", got[base]); end
        pressed = '0;
        tick(5 * FRAME);
    endtask

    task automatic test_random();
        bit mst[NK];
        int mcnt[NK];
        int exp[$];
        int base, nfr;
        do_reset();
        evt_ready = 1'b1;
        base = got.size();
        for (int k = 0; k < NK; k++) begin mst[k] = 1'b0; mcnt[k] = 0; end
        for (int seg = 0; seg < 16; seg++) begin
            pressed = NK'($urandom & $urandom);
            nfr = (seg == 15) ? 5 : $urandom_range(1, 5);
            if (seg == 15) pressed = '0;
            for (int f = 0; f < nfr; f++) begin
                // One frame: every key sees the level held for the whole frame, events in code order.
                for (int k = 0; k < NK; k++) begin
                    if (pressed[k] == mst[k]) mcnt[k] = 0;
                    else begin
                        mcnt[k]++;
                        if (mcnt[k] == DB) begin
                            mst[k] = pressed[k];
                            mcnt[k] = 0;
                            exp.push_back(pressed[k] ? k : 32 + k);
                        end
                    end
                end
                tick(FRAME);
            end
        end
        tick(SDIV * 2);
        checks++; if (got.size() - base != exp.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", got.size() - base, exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (got.size() <= base + i || got[base+i] != exp[i]) begin
                errors++; $display("FAIL rand_evt%0d got %0d want %0d", i, (got.size() > base + i) ? got[base+i] : -1, exp[i]);
            end
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rand_overflow got %b want 0", overflow); end
    endtask

    task automatic test_repeat();
        int base;
        int exp[4] = '{7, 7, 7, 39};
        do_reset();
        evt_ready = 1'b1;
        base = got.size();
        pressed[7] = 1'b1;
        tick(8 * FRAME);
        pressed[7] = 1'b0;
        tick(5 * FRAME);
        checks++; if (got.size() - base != 4) begin errors++; $display("FAIL rep_count got %0d want 4", got.size() - base); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got.size() > base + i && got[base+i] != exp[i]) begin errors++; $display("FAIL rep_evt%0d got %0d want %0d", i, got[base+i], exp[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
`ifdef KEYPAD_REPEAT_EN
        test_repeat();
`else
        test_press_release();
        test_glitch();
        test_overflow();
        test_simul_push_pop();
        test_reset_mid();
        test_random();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
